rst_seq: RTL and testbench

Multi-channel reset synchronizer and sequencer for the fabric reset tree. It brings an external reset request into the `clk` domain through a configurable synchronizer chain and holds all downstream domains in reset for a minimum hold time. It then releases NUM_CH active-low resets one at a time, in ascending channel order, with a fixed gap between releases. Once sequencing completes, each channel can be re-reset on its own by a software pulse without disturbing the other channels.

---
 rtl/rst_seq.sv | 205 ++++++++++++++++++++
 tb/tb_rst_seq.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rst_seq.sv
// rst_seq: multi-channel reset synchronizer and sequencer.
// An external reset request is synchronized into clk, held for a minimum
// time, then NUM_CH active-low resets are released one by one in
// ascending order with a fixed gap. After sequencing, each channel can be
// re-reset on its own by a software pulse. A low synchronized request
// at any time aborts everything back to the reset state.
module rst_seq #(
    parameter int NUM_CH      = 4,
    parameter int SYNC_STAGES = 2,
    parameter int HOLD_CYCLES = 8,
    parameter int GAP_CYCLES  = 4
) (
    input  logic              clk,
    input  logic              rstn_master,
    input  logic              rstn_in,
    input  logic [NUM_CH-1:0] sw_rst_req,
    output logic [NUM_CH-1:0] rstn_out,
    output logic              busy,
    output logic              seq_done
);

    // Counter sizing: one counter width serves hold, gap and soft-reset timing.
    localparam int MAX_CNT = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int CW      = $clog2(MAX_CNT + 1);
    localparam int CHW     = $clog2(NUM_CH + 1);

    localparam logic [CW-1:0]  CNT_ZERO  = {CW{1'b0}};
    localparam logic [CW-1:0]  CNT_ONE   = CW'(1);
    localparam logic [CW-1:0]  HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0]  GAP_LAST  = CW'(GAP_CYCLES - 1);
    localparam logic [CW-1:0]  HOLD_LOAD = CW'(HOLD_CYCLES);
    localparam logic [CHW-1:0] CH_ZERO   = {CHW{1'b0}};
    localparam logic [CHW-1:0] CH_ONE    = CHW'(1);
    localparam logic [CHW-1:0] CH_LAST   = CHW'(NUM_CH - 1);

    typedef enum logic [1:0] {
        ST_RESET   = 2'b00,
        ST_HOLD    = 2'b01,
        ST_RELEASE = 2'b10,
        ST_DONE    = 2'b11
    } state_t;

    // Synchronizer chain; sync_q_s is the last stage.
    logic [SYNC_STAGES-1:0] sync_r;
    logic                   sync_q_s;

    // Sequencer state.
    state_t            state_r, state_s;
    logic [CW-1:0]     cnt_r, cnt_s;
    logic [CHW-1:0]    ch_r, ch_s;
    logic [NUM_CH-1:0] out_r, out_s;
    logic              busy_r, busy_s;
    logic              done_r, done_s;

    // Per-channel soft-reset countdown; non-zero means the channel is held low.
    logic [CW-1:0] sw_cnt_r [NUM_CH];
    logic [CW-1:0] sw_cnt_s [NUM_CH];

    assign sync_q_s = sync_r[SYNC_STAGES-1];
    assign rstn_out = out_r;
    assign busy     = busy_r;
    assign seq_done = done_r;

    // Shift the external reset request through the synchronizer chain.
    always_ff @(posedge clk or negedge rstn_master) begin
        if (!rstn_master) begin
            sync_r <= {SYNC_STAGES{1'b0}};
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], rstn_in};
        end
    end

    // Sequencer state and output registers.
    always_ff @(posedge clk or negedge rstn_master) begin
        if (!rstn_master) begin
            state_r <= ST_RESET;
            cnt_r   <= CNT_ZERO;
            ch_r    <= CH_ZERO;
            out_r   <= {NUM_CH{1'b0}};
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                sw_cnt_r[i] <= CNT_ZERO;
            end
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            ch_r    <= ch_s;
            out_r   <= out_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
            for (int i = 0; i < NUM_CH; i++) begin
                sw_cnt_r[i] <= sw_cnt_s[i];
            end
        end
    end

    // Next-state, counter and output computation for the sequencer.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        ch_s    = ch_r;
        out_s   = out_r;
        busy_s  = busy_r;
        done_s  = done_r;
        for (int i = 0; i < NUM_CH; i++) begin
            sw_cnt_s[i] = sw_cnt_r[i];
        end

        if (!sync_q_s) begin
            // A low synchronized request overrides everything, including
            // any soft reset arriving on the same edge.
            state_s = ST_RESET;
            cnt_s   = CNT_ZERO;
            ch_s    = CH_ZERO;
            out_s   = {NUM_CH{1'b0}};
            busy_s  = 1'b0;
            done_s  = 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                sw_cnt_s[i] = CNT_ZERO;
            end
        end else begin
            case (state_r)
                ST_RESET: begin
                    state_s = ST_HOLD;
                    cnt_s   = CNT_ZERO;
                    ch_s    = CH_ZERO;
                    out_s   = {NUM_CH{1'b0}};
                    busy_s  = 1'b1;
                    done_s  = 1'b0;
                end
                ST_HOLD: begin
                    if (cnt_r == HOLD_LAST) begin
                        cnt_s    = CNT_ZERO;
                        out_s[0] = 1'b1;
                        if (NUM_CH == 1) begin
                            // Single channel: the hold release is also the last release.
                            state_s = ST_DONE;
                            ch_s    = CH_ZERO;
                            busy_s  = 1'b0;
                            done_s  = 1'b1;
                        end else begin
                            state_s = ST_RELEASE;
                            ch_s    = CH_ONE;
                        end
                    end else begin
                        cnt_s = cnt_r + CNT_ONE;
                    end
                end
                ST_RELEASE: begin
                    if (cnt_r == GAP_LAST) begin
                        cnt_s = CNT_ZERO;
                        ch_s  = ch_r + CH_ONE;
                        for (int i = 0; i < NUM_CH; i++) begin
                            if (ch_r == CHW'(i)) begin
                                out_s[i] = 1'b1;
                            end else begin
                                out_s[i] = out_r[i];
                            end
                        end
                        if (ch_r == CH_LAST) begin
                            state_s = ST_DONE;
                            busy_s  = 1'b0;
                            done_s  = 1'b1;
                        end else begin
                            state_s = ST_RELEASE;
                        end
                    end else begin
                        cnt_s = cnt_r + CNT_ONE;
                    end
                end
                ST_DONE: begin
                    busy_s = 1'b0;
                    done_s = 1'b1;
                    // Each channel runs its own soft-reset countdown; a new
                    // request while low simply reloads it.
                    for (int i = 0; i < NUM_CH; i++) begin
                        if (sw_rst_req[i]) begin
                            sw_cnt_s[i] = HOLD_LOAD;
                            out_s[i]    = 1'b0;
                        end else if (sw_cnt_r[i] != CNT_ZERO) begin
                            sw_cnt_s[i] = sw_cnt_r[i] - CNT_ONE;
                            if (sw_cnt_r[i] == CNT_ONE) begin
                                out_s[i] = 1'b1;
                            end else begin
                                out_s[i] = 1'b0;
                            end
                        end else begin
                            out_s[i] = 1'b1;
                        end
                    end
                end
                default: begin
                    state_s = ST_RESET;
                    cnt_s   = CNT_ZERO;
                    ch_s    = CH_ZERO;
                    out_s   = {NUM_CH{1'b0}};
                    busy_s  = 1'b0;
                    done_s  = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rst_seq.sv
// tb_rst_seq: checks three rst_seq configurations against a timeline model.
// The model tracks, per configuration, how many consecutive edges the
// synchronized request has been high and derives every release edge from
// the hold/gap arithmetic; soft resets are tracked as per-channel end edges.
module tb_rst_seq;

    logic       clk = 1'b0;
    logic       rstn_master = 1'b0;
    logic       rstn_in = 1'b0;
    logic [3:0] req0 = 4'b0;
    logic [0:0] req1 = 1'b0;
    logic [7:0] req2 = 8'b0;
    logic [3:0] out0;
    logic [0:0] out1;
    logic [7:0] out2;
    logic       busy0, busy1, busy2;
    logic       done0, done1, done2;

    rst_seq #(.NUM_CH(4), .SYNC_STAGES(2), .HOLD_CYCLES(8), .GAP_CYCLES(4)) u_dut0 (
        .clk(clk), .rstn_master(rstn_master), .rstn_in(rstn_in), .sw_rst_req(req0),
        .rstn_out(out0), .busy(busy0), .seq_done(done0));
    rst_seq #(.NUM_CH(1), .SYNC_STAGES(3), .HOLD_CYCLES(1), .GAP_CYCLES(1)) u_dut1 (
        .clk(clk), .rstn_master(rstn_master), .rstn_in(rstn_in), .sw_rst_req(req1),
        .rstn_out(out1), .busy(busy1), .seq_done(done1));
    rst_seq #(.NUM_CH(8), .SYNC_STAGES(2), .HOLD_CYCLES(16), .GAP_CYCLES(4)) u_dut2 (
        .clk(clk), .rstn_master(rstn_master), .rstn_in(rstn_in), .sw_rst_req(req2),
        .rstn_out(out2), .busy(busy2), .seq_done(done2));

    always #5 clk = ~clk;

    int P_N [3] = '{4, 1, 8};
    int P_S [3] = '{2, 3, 2};
    int P_H [3] = '{8, 1, 16};
    int P_G [3] = '{4, 1, 4};

    int n_cmp = 0;
    int n_bad = 0;
    int edge_n = -1;

    // Inputs as seen by each posedge.
    logic       cap_mr = 1'b0;
    logic       cap_in = 1'b0;
    logic [7:0] cap_req [3];

    // Model state.
    bit samp_q [$];
    int run_m [3];
    int soft_end [3][8];
    bit done_m [3];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at edge %0d: got %0h, want %0h", nm, edge_n, act, exp);
        end
    endtask

    function automatic bit sq_at(input int s, input int x);
        int idx;
        idx = x - s + 1;
        if (idx < 0) return 1'b0;
        return samp_q[idx];
    endfunction

    function automatic logic [7:0] dut_out(input int k);
        case (k)
            0:       return {4'b0, out0};
            1:       return {7'b0, out1};
            default: return out2;
        endcase
    endfunction

    function automatic logic dut_busy(input int k);
        case (k)
            0:       return busy0;
            1:       return busy1;
            default: return busy2;
        endcase
    endfunction

    function automatic logic dut_done(input int k);
        case (k)
            0:       return done0;
            1:       return done1;
            default: return done2;
        endcase
    endfunction

    // Capture what each active edge samples.
    always @(posedge clk) begin
        cap_mr     <= rstn_master;
        cap_in     <= rstn_in;
        cap_req[0] <= {4'b0, req0};
        cap_req[1] <= {7'b0, req1};
        cap_req[2] <= req2;
    end

    // Advance the model by one edge and compare every output.
    always @(negedge clk) begin : model_cmp
        int n;
        bit sqp;
        bit all_rel;
        bit bsy;
        logic [7:0] o;
        samp_q.push_back(cap_mr ? cap_in : 1'b0);
        n = samp_q.size() - 1;
        for (int k = 0; k < 3; k++) begin
            sqp = sq_at(P_S[k], n - 1);
            if (!cap_mr || !sqp) begin
                run_m[k] = 0;
                for (int i = 0; i < 8; i++) soft_end[k][i] = 0;
            end else begin
                run_m[k] = run_m[k] + 1;
            end
            o = 8'b0;
            for (int i = 0; i < P_N[k]; i++) begin
                if (run_m[k] >= 1 && run_m[k] - 1 >= P_H[k] + i * P_G[k]) o[i] = 1'b1;
            end
            all_rel = o[P_N[k]-1];
            bsy = (run_m[k] >= 1) && !all_rel;
            for (int i = 0; i < P_N[k]; i++) begin
                if (cap_mr && sqp && done_m[k] && cap_req[k][i]) soft_end[k][i] = n + P_H[k];
                if (n < soft_end[k][i]) o[i] = 1'b0;
            end
            done_m[k] = all_rel;
            edge_n = n;
            chk($sformatf("rstn_out[inst%0d]", k), 32'(dut_out(k)), 32'(o));
            chk($sformatf("busy[inst%0d]", k), 32'(dut_busy(k)), 32'(bsy));
            chk($sformatf("seq_done[inst%0d]", k), 32'(dut_done(k)), 32'(all_rel));
        end
    end

    task automatic wait_to(input int t);
        while (edge_n < t) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic check_all_zero(input string nm);
        chk({nm, "_out0"}, 32'(out0), 32'(4'b0));
        chk({nm, "_out1"}, 32'(out1), 32'(1'b0));
        chk({nm, "_out2"}, 32'(out2), 32'(8'b0));
        chk({nm, "_busy"}, 32'({busy0, busy1, busy2}), 32'(3'b0));
        chk({nm, "_done"}, 32'({done0, done1, done2}), 32'(3'b0));
    endtask

    // Pull the master reset low mid-cycle, check the immediate clear, hold, release.
    task automatic do_master();
        @(negedge clk);
        #1;
        rstn_master = 1'b0;
        #1;
        check_all_zero("async_master");
        repeat (4) @(negedge clk);
        #1;
        rstn_master = 1'b1;
    endtask

    int k0;
    int e;

    initial begin
        #2;
        check_all_zero("reset");
        wait_to(3);
        rstn_master = 1'b1;
        wait_to(5);
        // Power-up sequence with hand-computed release edges.
        rstn_in = 1'b1;
        k0 = edge_n + 1;
        wait_to(k0 + 3);  chk("inst1_before_T0", 32'(out1), 32'(1'b0));
        wait_to(k0 + 4);  chk("inst1_at_T0", 32'({out1, done1}), 32'(2'b11));
        wait_to(k0 + 9);  chk("pwr_k9", 32'(out0), 32'(4'b0000));
        wait_to(k0 + 10); chk("pwr_k10", 32'({out0, busy0}), 32'(5'b0001_1));
        wait_to(k0 + 11); req0 = 4'b1111; req2 = 8'hFF;
        wait_to(k0 + 14); chk("pwr_k14", 32'(out0), 32'(4'b0011));
        wait_to(k0 + 18); chk("pwr_k18", 32'(out0), 32'(4'b0111));
        wait_to(k0 + 20); req0 = 4'b0; req2 = 8'h0;
        wait_to(k0 + 21); chk("pwr_k21", 32'({busy0, done0}), 32'(2'b10));
        wait_to(k0 + 22); chk("pwr_k22", 32'({out0, busy0, done0}), 32'(6'b1111_01));
        wait_to(k0 + 45); chk("inst2_k45", 32'(out2), 32'(8'h7F));
        wait_to(k0 + 46); chk("inst2_k46", 32'({out2, done2}), 32'(9'h1FF));
        wait_to(k0 + 50);

        // Single soft reset on channel 2.
        e = edge_n + 1; req0 = 4'b0100;
        wait_to(e);     req0 = 4'b0; chk("soft_e", 32'(out0), 32'(4'b1011));
        wait_to(e + 7); chk("soft_e7", 32'(out0), 32'(4'b1011));
        wait_to(e + 8); chk("soft_e8", 32'(out0), 32'(4'b1111));

        // Re-pulse while low extends the hold.
        e = edge_n + 1; req0 = 4'b0100;
        wait_to(e);      req0 = 4'b0;
        wait_to(e + 2);  req0 = 4'b0100;
        wait_to(e + 3);  req0 = 4'b0;
        wait_to(e + 10); chk("repulse_e10", 32'(out0), 32'(4'b1011));
        wait_to(e + 11); chk("repulse_e11", 32'(out0), 32'(4'b1111));

        // Simultaneous soft resets.
        e = edge_n + 1; req0 = 4'b1001;
        wait_to(e);     req0 = 4'b0; chk("simul_e", 32'(out0), 32'(4'b0110));
        wait_to(e + 7); chk("simul_e7", 32'(out0), 32'(4'b0110));
        wait_to(e + 8); chk("simul_e8", 32'(out0), 32'(4'b1111));

        // Abort mid-sequence, then restart.
        rstn_in = 1'b0;
        wait_to(edge_n + 6);
        rstn_in = 1'b1;
        k0 = edge_n + 1;
        wait_to(k0 + 14); rstn_in = 1'b0;
        wait_to(k0 + 16); chk("abort_k16", 32'({out0, busy0}), 32'(5'b0011_1));
        wait_to(k0 + 17); chk("abort_k17", 32'({out0, busy0, done0}), 32'(6'b0));
        wait_to(edge_n + 3);
        rstn_in = 1'b1;
        k0 = edge_n + 1;
        wait_to(k0 + 21); chk("restart_k21", 32'(out0), 32'(4'b0111));
        wait_to(k0 + 22); chk("restart_k22", 32'({out0, done0}), 32'(5'b1111_1));

        // Master reset in the middle of a sequence.
        do_master();
        k0 = edge_n + 1;
        wait_to(k0 + 12);
        do_master();
        k0 = edge_n + 1;
        wait_to(k0 + 9);  chk("mst_k9", 32'(out0), 32'(4'b0000));
        wait_to(k0 + 10); chk("mst_k10", 32'(out0), 32'(4'b0001));

        // Randomized traffic, checked every cycle by the model.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            #1;
            if ($urandom_range(0, 69) == 0) rstn_in = ~rstn_in;
            req0 = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'b0;
            req1 = ($urandom_range(0, 5) == 0) ? 1'($urandom) : 1'b0;
            req2 = ($urandom_range(0, 5) == 0) ? 8'($urandom) : 8'b0;
            if ($urandom_range(0, 599) == 0) do_master();
        end
        req0 = 4'b0; req1 = 1'b0; req2 = 8'b0;
        wait_to(edge_n + 4);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
